// File: rtl/cp0_exc_unit_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, field positions
// and the default exception vector.
package cp0_defs;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    typedef enum logic [4:0] {
        EXC_INT  = 5'h00,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0A,
        EXC_OV   = 5'h0C
    } excCodeT;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int CAUSE_TI   = 30;
    localparam int CAUSE_BD   = 31;

    // Status bits software may change with mtc0: IM[15:8], EXL, IE.
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    localparam logic [31:0] CP0_EXC_VECTOR = 32'hBFC0_0380;
    localparam logic [31:0] CP0_STATUS_RST = 32'h0040_0000;

endpackage

// File: rtl/cp0_exc_unit_timer.sv
// CP0 Count/Compare timer: Count advances every second clock, TI latches on
// a Count==Compare match and is cleared only by a write to Compare.
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        countWe,
    input  logic        compareWe,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timerInt
);

    logic halfTick;

    // Timer state; keeps running while the pipeline is stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halfTick <= 1'b0;
            count    <= 32'd0;
            compare  <= 32'd0;
            timerInt <= 1'b0;
        end else begin
            halfTick <= ~halfTick;
            if (countWe)
                count <= wdata;
            else if (halfTick)
                count <= count + 32'd1;
            if (compareWe)
                compare <= wdata;
            // A Compare write acknowledges the interrupt and beats a same-cycle match.
            if (compareWe)
                timerInt <= 1'b0;
            else if ((compare != 32'd0) && (count == compare))
                timerInt <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_exc_unit.sv
// Memory-stage precise exception resolution and CP0 register file.
module cp0_exc_unit
    import cp0_defs::*;
#(
    parameter logic [31:0] EXC_VECTOR = CP0_EXC_VECTOR,
    parameter logic [31:0] STATUS_RST = CP0_STATUS_RST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallM,
    input  logic        validM,
    input  logic [31:0] pcM,
    input  logic        is_in_slotM,
    input  logic        adel_ifM,
    input  logic        riM,
    input  logic        ovM,
    input  logic        syscallM,
    input  logic        breakM,
    input  logic        adel_dataM,
    input  logic        ades_dataM,
    input  logic        eretM,
    input  logic [31:0] bad_addrM,
    input  logic        cp0_weM,
    input  logic [4:0]  cp0_waddrM,
    input  logic [31:0] cp0_wdataM,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    input  logic [5:0]  int_i,
    output logic        exc_flush,
    output logic [4:0]  exc_code,
    output logic [31:0] exc_pc,
    output logic [31:0] epc_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic        timer_int
);

    logic [31:0] status;
    logic [31:0] epc;
    logic [31:0] badVAddr;
    logic        causeBd;
    logic [5:0]  causeIpHw;
    logic [1:0]  causeIpSw;
    logic [4:0]  causeExcCode;
    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] causeVal;

    logic        intPend;
    logic        excValid;
    logic [4:0]  excCodeSel;
    logic        selIfAddr;
    logic        selDataAddr;
    logic        eretTake;
    logic        excTake;
    logic        eretCommit;
    logic        cp0Write;

    assign causeVal = {causeBd, timer_int, 14'd0, causeIpHw, causeIpSw, 1'b0, causeExcCode, 2'b00};
    assign intPend  = status[STATUS_IE] & ~status[STATUS_EXL]
                    & (|({causeIpHw, causeIpSw} & status[15:8]));

    // Priority encoder over the M-stage exception sources.
    always_comb begin
        excValid    = 1'b0;
        excCodeSel  = EXC_INT;
        selIfAddr   = 1'b0;
        selDataAddr = 1'b0;
        if (validM) begin
            if (intPend) begin
                excValid = 1'b1; excCodeSel = EXC_INT;
            end else if (adel_ifM) begin
                excValid = 1'b1; excCodeSel = EXC_ADEL; selIfAddr = 1'b1;
            end else if (riM) begin
                excValid = 1'b1; excCodeSel = EXC_RI;
            end else if (ovM) begin
                excValid = 1'b1; excCodeSel = EXC_OV;
            end else if (syscallM) begin
                excValid = 1'b1; excCodeSel = EXC_SYS;
            end else if (breakM) begin
                excValid = 1'b1; excCodeSel = EXC_BP;
            end else if (adel_dataM) begin
                excValid = 1'b1; excCodeSel = EXC_ADEL; selDataAddr = 1'b1;
            end else if (ades_dataM) begin
                excValid = 1'b1; excCodeSel = EXC_ADES; selDataAddr = 1'b1;
            end
        end
    end

    // eret yields to any exception on the same instruction; an excepting
    // instruction never commits its mtc0.
    assign eretTake   = validM & eretM & ~excValid;
    assign excTake    = excValid & ~stallM;
    assign eretCommit = eretTake & ~stallM;
    assign cp0Write   = cp0_weM & ~stallM & ~excValid & ~eretTake;

    assign exc_flush = excTake | eretCommit;
    assign exc_code  = excValid ? excCodeSel : 5'd0;
    assign exc_pc    = excValid ? EXC_VECTOR : (eretTake ? epc : 32'd0);

    cp0_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .countWe   (cp0Write && (cp0_waddrM == CP0_COUNT)),
        .compareWe (cp0Write && (cp0_waddrM == CP0_COMPARE)),
        .wdata     (cp0_wdataM),
        .count     (count),
        .compare   (compare),
        .timerInt  (timer_int)
    );

    // CP0 register updates: hardware IP sampling, exception entry, eret, mtc0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status       <= STATUS_RST;
            epc          <= 32'd0;
            badVAddr     <= 32'd0;
            causeBd      <= 1'b0;
            causeIpHw    <= 6'd0;
            causeIpSw    <= 2'd0;
            causeExcCode <= 5'd0;
        end else begin
            causeIpHw <= {int_i[5] | timer_int, int_i[4:0]};
            if (excTake) begin
                // Nested exceptions keep the EPC/BD of the original fault.
                if (!status[STATUS_EXL]) begin
                    epc     <= is_in_slotM ? (pcM - 32'd4) : pcM;
                    causeBd <= is_in_slotM;
                end
                status[STATUS_EXL] <= 1'b1;
                causeExcCode       <= excCodeSel;
                if (selIfAddr)
                    badVAddr <= pcM;
                else if (selDataAddr)
                    badVAddr <= bad_addrM;
            end else if (eretCommit) begin
                status[STATUS_EXL] <= 1'b0;
            end else if (cp0Write) begin
                case (cp0_waddrM)
                    CP0_STATUS: status    <= (status & ~STATUS_WMASK) | (cp0_wdataM & STATUS_WMASK);
                    CP0_CAUSE:  causeIpSw <= cp0_wdataM[9:8];
                    CP0_EPC:    epc       <= cp0_wdataM;
                    default: ;
                endcase
            end
        end
    end

    // mfc0 read port; unimplemented registers read as zero.
    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_raddr)
            CP0_BADVADDR: cp0_rdata = badVAddr;
            CP0_COUNT:    cp0_rdata = count;
            CP0_COMPARE:  cp0_rdata = compare;
            CP0_STATUS:   cp0_rdata = status;
            CP0_CAUSE:    cp0_rdata = causeVal;
            CP0_EPC:      cp0_rdata = epc;
            default:      cp0_rdata = 32'd0;
        endcase
    end

    assign epc_o    = epc;
    assign status_o = status;
    assign cause_o  = causeVal;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Bench for cp0_exc_unit: hand sequences for the multi-cycle cases and a
// vector table for the exception priority order.
module tb_cp0_exc_unit;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallM, validM, is_in_slotM;
    logic [31:0] pcM, bad_addrM, cp0_wdataM;
    logic        adel_ifM, riM, ovM, syscallM, breakM, adel_dataM, ades_dataM, eretM;
    logic        cp0_weM;
    logic [4:0]  cp0_waddrM, cp0_raddr;
    logic [31:0] cp0_rdata;
    logic [5:0]  int_i;
    logic        exc_flush;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc, epc_o, status_o, cause_o;
    logic        timer_int;

    int checks = 0;
    int failures = 0;
    logic [37:0] exp_q[$];

    typedef struct {
        logic        valid;
        logic [7:0]  flags;   // adel_if, ri, ov, sys, brk, adel_data, ades_data, eret
        logic        exp_flush;
        logic [4:0]  exp_code;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[13];

    cp0_exc_unit dut (
        .clk(clk), .rst(rst), .stallM(stallM), .validM(validM), .pcM(pcM),
        .is_in_slotM(is_in_slotM), .adel_ifM(adel_ifM), .riM(riM), .ovM(ovM),
        .syscallM(syscallM), .breakM(breakM), .adel_dataM(adel_dataM),
        .ades_dataM(ades_dataM), .eretM(eretM), .bad_addrM(bad_addrM),
        .cp0_weM(cp0_weM), .cp0_waddrM(cp0_waddrM), .cp0_wdataM(cp0_wdataM),
        .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata), .int_i(int_i),
        .exc_flush(exc_flush), .exc_code(exc_code), .exc_pc(exc_pc),
        .epc_o(epc_o), .status_o(status_o), .cause_o(cause_o), .timer_int(timer_int)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stallM = 0; validM = 0; pcM = 0; is_in_slotM = 0;
        adel_ifM = 0; riM = 0; ovM = 0; syscallM = 0; breakM = 0;
        adel_dataM = 0; ades_dataM = 0; eretM = 0; bad_addrM = 0;
        cp0_weM = 0; cp0_waddrM = 0; cp0_wdataM = 0; cp0_raddr = 0; int_i = 0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Push the expected flush/code/pc, then pop and compare at the negedge.
    task automatic expect_out(input string name, input logic flush, input logic [4:0] code,
                              input logic [31:0] pc);
        logic [37:0] got, want;
        exp_q.push_back({flush, code, pc});
        @(negedge clk);
        got  = {exc_flush, exc_code, exc_pc};
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s actual flush/code/pc=%b/%h/%h expected=%b/%h/%h", name,
                     got[37], got[36:32], got[31:0], want[37], want[36:32], want[31:0]);
        end
    endtask

    task automatic read_cp0(input logic [4:0] a, output logic [31:0] d);
        cp0_raddr = a;
        #1;
        d = cp0_rdata;
    endtask

    task automatic mtc0(input string name, input logic [4:0] a, input logic [31:0] d);
        validM = 1; cp0_weM = 1; cp0_waddrM = a; cp0_wdataM = d; pcM = 32'hBFC0_1000;
        expect_out(name, 1'b0, 5'd0, 32'd0);
        tick();
        clear_inputs();
    endtask

    initial begin
        logic [31:0] rd, prev_cnt;
        logic found;

        // Reset
        rst = 0;
        clear_inputs();
        repeat (2) tick();
        expect_out("reset_out", 1'b0, 5'd0, 32'd0);
        read_cp0(5'd12, rd); check("reset_status", rd, 32'h0040_0000);
        read_cp0(5'd9, rd);  check("reset_count", rd, 32'd0);
        tick();
        rst = 1;
        repeat (10) tick();
        read_cp0(5'd9, rd);  check("idle_count", rd, 32'd5);
        read_cp0(5'd12, rd); check("idle_status", rd, 32'h0040_0000);
        expect_out("idle_out", 1'b0, 5'd0, 32'd0);
        tick();

        // Overflow outside a delay slot
        validM = 1; ovM = 1; pcM = 32'hBFC0_0100;
        expect_out("ov_out", 1'b1, 5'h0C, VEC);
        tick(); clear_inputs();
        read_cp0(5'd14, rd); check("ov_epc", rd, 32'hBFC0_0100);
        read_cp0(5'd12, rd); check("ov_status", rd, 32'h0040_0002);
        read_cp0(5'd13, rd); check("ov_cause_bd_code", {26'd0, rd[31], rd[6:2]}, {26'd0, 1'b0, 5'h0C});

        // eret back
        validM = 1; eretM = 1;
        expect_out("eret1_out", 1'b1, 5'd0, 32'hBFC0_0100);
        tick(); clear_inputs();
        read_cp0(5'd12, rd); check("eret1_status", rd, 32'h0040_0000);

        // Load address error in a delay slot
        validM = 1; adel_dataM = 1; bad_addrM = 32'h0000_0003; is_in_slotM = 1; pcM = 32'hBFC0_0204;
        expect_out("adel_out", 1'b1, 5'h04, VEC);
        tick(); clear_inputs();
        read_cp0(5'd14, rd); check("adel_epc", rd, 32'hBFC0_0200);
        read_cp0(5'd13, rd); check("adel_bd", {31'd0, rd[31]}, 32'd1);
        read_cp0(5'd8, rd);  check("adel_badvaddr", rd, 32'h0000_0003);

        // Timer interrupt
        mtc0("mtc0_status", 5'd12, 32'h0000_FF01);
        read_cp0(5'd12, rd); check("mtc0_status_val", rd, 32'h0040_FF01);
        mtc0("mtc0_count", 5'd9, 32'd0);
        mtc0("mtc0_compare", 5'd11, 32'd3);
        found = 0; prev_cnt = 32'hFFFF_FFFF;
        for (int i = 0; i < 40; i++) begin
            read_cp0(5'd9, rd);
            if (timer_int) begin found = 1; break; end
            prev_cnt = rd;
            tick();
        end
        check("ti_seen", {31'd0, found}, 32'd1);
        check("ti_count_at_match", prev_cnt, 32'd3);
        tick();
        validM = 1; pcM = 32'hBFC0_0300;
        expect_out("int_out", 1'b1, 5'h00, VEC);
        tick(); clear_inputs();
        read_cp0(5'd14, rd); check("int_epc", rd, 32'hBFC0_0300);
        read_cp0(5'd12, rd); check("int_status", rd, 32'h0040_FF03);
        mtc0("mtc0_compare_clr", 5'd11, 32'd0);
        check("ti_cleared", {31'd0, timer_int}, 32'd0);

        // ri beats adel_data; BadVAddr untouched
        validM = 1; riM = 1; adel_dataM = 1; bad_addrM = 32'h0000_1234; pcM = 32'hBFC0_0400;
        expect_out("ri_adel_out", 1'b1, 5'h0A, VEC);
        tick(); clear_inputs();
        read_cp0(5'd8, rd);  check("ri_badvaddr", rd, 32'h0000_0003);
        read_cp0(5'd14, rd); check("nested_epc", rd, 32'hBFC0_0300);
        validM = 1; eretM = 1;
        expect_out("eret2_out", 1'b1, 5'd0, 32'hBFC0_0300);
        tick(); clear_inputs();
        read_cp0(5'd12, rd); check("eret2_status", rd, 32'h0040_FF01);

        // mtc0 on an excepting instruction is dropped
        validM = 1; ovM = 1; cp0_weM = 1; cp0_waddrM = 5'd14; cp0_wdataM = 32'hDEAD_BEEF;
        pcM = 32'hBFC0_0500;
        expect_out("ov_mtc0_out", 1'b1, 5'h0C, VEC);
        tick(); clear_inputs();
        read_cp0(5'd14, rd); check("ov_mtc0_epc", rd, 32'hBFC0_0500);
        validM = 1; eretM = 1;
        expect_out("eret3_out", 1'b1, 5'd0, 32'hBFC0_0500);
        tick(); clear_inputs();

        // Stalled overflow: no flush, no commit until the stall drops
        stallM = 1; validM = 1; ovM = 1; pcM = 32'hBFC0_0600;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("stall_noflush", {31'd0, exc_flush}, 32'd0);
            tick();
        end
        read_cp0(5'd12, rd); check("stall_status", rd, 32'h0040_FF01);
        read_cp0(5'd14, rd); check("stall_epc", rd, 32'hBFC0_0500);
        stallM = 0;
        expect_out("unstall_out", 1'b1, 5'h0C, VEC);
        tick(); clear_inputs();
        read_cp0(5'd14, rd); check("unstall_epc", rd, 32'hBFC0_0600);

        // Priority table (EXL=1 here, so no interrupt and EPC holds)
        vecs[0]  = '{1'b1, 8'b1000_0000, 1'b1, 5'h04, VEC};
        vecs[1]  = '{1'b1, 8'b1100_0000, 1'b1, 5'h04, VEC};
        vecs[2]  = '{1'b1, 8'b0110_0000, 1'b1, 5'h0A, VEC};
        vecs[3]  = '{1'b1, 8'b0011_0000, 1'b1, 5'h0C, VEC};
        vecs[4]  = '{1'b1, 8'b0001_1000, 1'b1, 5'h08, VEC};
        vecs[5]  = '{1'b1, 8'b0000_1100, 1'b1, 5'h09, VEC};
        vecs[6]  = '{1'b1, 8'b0000_0110, 1'b1, 5'h04, VEC};
        vecs[7]  = '{1'b1, 8'b0000_0010, 1'b1, 5'h05, VEC};
        vecs[8]  = '{1'b0, 8'b0010_0000, 1'b0, 5'h00, 32'd0};
        vecs[9]  = '{1'b1, 8'b0000_0000, 1'b0, 5'h00, 32'd0};
        vecs[10] = '{1'b1, 8'b0010_0001, 1'b1, 5'h0C, VEC};
        vecs[11] = '{1'b1, 8'b0001_0001, 1'b1, 5'h08, VEC};
        vecs[12] = '{1'b1, 8'b0000_0001, 1'b1, 5'h00, 32'hBFC0_0600};
        for (int i = 0; i < 13; i++) begin
            validM = vecs[i].valid;
            {adel_ifM, riM, ovM, syscallM, breakM, adel_dataM, ades_dataM, eretM} = vecs[i].flags;
            pcM = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            bad_addrM = $urandom_range(0, 32'h7FFF_FFFF);
            expect_out($sformatf("vec%0d", i), vecs[i].exp_flush, vecs[i].exp_code, vecs[i].exp_pc);
            tick();
            clear_inputs();
        end
        read_cp0(5'd12, rd); check("final_status", rd, 32'h0040_FF01);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
- Memory-stage exception and coprocessor-0 block for the 5-stage MIPS core.
- Consumes the per-instruction exception flags and delay-slot tag produced alongside the pipeline control (overflow, load address error, branch-delay-slot marker, eret, mtc0/mfc0).
- Resolves one precise exception per cycle in M, updates the CP0 registers, and drives the pipeline-wide flush and redirect PC consumed by the hazard unit and PC mux.
- Owns the CP0 registers BadVAddr, Count, Compare, Status, Cause and EPC, plus the timer interrupt.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, target PC for all exceptions and interrupts.
- STATUS_RST, 32'h0040_0000, Status reset value (BEV=1, IE=0, EXL=0).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous reset, active-low (block is in reset while rst=0).
- stallM  in  1  M stage held; no architectural state may commit.
- validM  in  1  M holds a real instruction (not a bubble).
- pcM  in  32  PC of the M instruction.
- is_in_slotM  in  1  M instruction sits in a branch delay slot.
- adel_ifM, riM, ovM, syscallM, breakM, adel_dataM, ades_dataM  in  1 each  exception flags.
- eretM  in  1  eret in M.
- bad_addrM  in  32  faulting data address.
- cp0_weM  in  1  mtc0 commit request.
- cp0_waddrM  in  5  mtc0 register number.
- cp0_wdataM  in  32  mtc0 data.
- cp0_raddr  in  5  mfc0 read address.
- cp0_rdata  out  32  mfc0 data (combinational read).
- int_i  in  6  external hardware interrupts, level.
- exc_flush  out  1  flush F/D/E/M/W this cycle.
- exc_code  out  5  Cause.ExcCode of the exception being taken.
- exc_pc  out  32  redirect PC.
- epc_o, status_o, cause_o  out  32 each  current register values.
- timer_int  out  1  Cause.TI.

Behaviour:
- Reset (rst=0): Status=STATUS_RST; Cause, EPC, BadVAddr, Count and Compare=0; the Count half-rate toggle=0. While reset is held, exc_flush=0, exc_code=0 and exc_pc=0, since they are derived from the reset Status and inputs gated by validM=0. Assertion mid-operation clears all state immediately.
- Pending interrupt: int_pend = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]).
- Cause.IP[7:2] = {int_i[5] | Cause.TI, int_i[4:0]}, sampled every cycle. IP[1:0] are written only by mtc0.
- Detection is combinational in M, qualified by validM. Priority, highest first, with ExcCode:
  1. Interrupt, 0x00.
  2. adel_if, 0x04.
  3. ri, 0x0A.
  4. ov, 0x0C.
  5. syscall, 0x08.
  6. break, 0x09.
  7. adel_data, 0x04.
  8. ades_data, 0x05.
- eret is treated as lowest priority.
- exc_flush = (exception | eret) & ~stallM.
- exc_pc = EXC_VECTOR for an exception, EPC for eret.
- On the clock edge where an exception is taken:
  - If Status.EXL=0: EPC = is_in_slotM ? pcM-4 : pcM, and Cause.BD = is_in_slotM.
  - If EXL was already 1: EPC and BD are unchanged.
  - Status.EXL=1 and Cause.ExcCode=code.
  - BadVAddr = pcM for adel_if, bad_addrM for adel_data or ades_data, otherwise unchanged.
- eret taken: Status.EXL=0.
- mtc0 is applied only if cp0_weM & ~stallM and no exception or eret is taken that cycle; an excepting instruction does not commit.
- Writable fields:
  - Status: IM[15:8], EXL[1], IE[0].
  - Cause: IP[9:8].
  - EPC, Count and Compare: full 32 bits.
  - BadVAddr is read-only.
- Count increments every second clock, via a 1-bit toggle.
  - An mtc0 to Count overrides the increment in that cycle.
- Cause.TI is set on the cycle Count==Compare while Compare!=0.
  - TI stays set until an mtc0 to Compare, which clears it. The clear wins over a simultaneous match.
- The mfc0 read of an unimplemented register returns 0. There is no read bypass of a same-cycle mtc0 (the hazard unit stalls for it).
- When stallM=1, no register updates occur except Count/TI/IP ticking, and exc_flush=0.

Decomposition:
- Shared package cp0_defs:
  - CP0 register numbers (8, 9, 11, 12, 13, 14).
  - ExcCode constants.
  - Status/Cause bit positions.
  - EXC_VECTOR.
- One natural sub-module: cp0_timer (Count, the toggle, Compare and TI, with its write ports).

Test Plan:
- Reset then 10 clocks idle: Count=5, Status=0x00400000, exc_flush=0.
- validM=1, ovM=1, pcM=0xBFC00100, is_in_slotM=0: exc_flush=1, exc_pc=0xBFC00380, exc_code=0x0C. Next cycle EPC=0xBFC00100, Status.EXL=1, Cause.BD=0.
- adel_dataM=1, bad_addrM=0x00000003, is_in_slotM=1, pcM=0xBFC00204: EPC=0xBFC00200, BD=1, BadVAddr=0x00000003, code 0x04.
- mtc0 Status=0x0000FF01, mtc0 Compare=3, then wait: TI sets when Count reaches 3. Next valid instruction gives exc_code=0x00. mtc0 Compare clears TI.
- Simultaneous riM and adel_dataM: code=0x0A and BadVAddr unchanged. Then eretM: exc_pc=EPC and EXL returns to 0.
- cp0_weM with ovM on the same instruction: the CP0 write is dropped. With stallM=1, ovM raises no flush until stallM falls.
